// File: rtl/platform_pkg.sv
// platform_pkg: shared constants, game-state codes, FSM states and the initial platform layout.
package platform_pkg;
  localparam int N_PLAT = 8;
  localparam int PLAT_SIZE = 60;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [7:0] MENU = 8'd0;
  localparam logic [7:0] PLAY = 8'd1;
  typedef enum logic [1:0] {IDLE, SCAN, INIT} fsm_t;
  localparam logic [9:0] INIT_X [N_PLAT] = '{10'd140, 10'd237, 10'd334, 10'd431, 10'd228, 10'd325, 10'd422, 10'd219};
  localparam logic [9:0] INIT_Y [N_PLAT] = '{10'd440, 10'd380, 10'd320, 10'd260, 10'd200, 10'd140, 10'd80, 10'd20};
endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR, seeded on reset.
module lfsr16
  import platform_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  output logic [15:0] value
);
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) value <= LFSR_SEED;
    else value <= value[0] ? (value >> 1) ^ LFSR_TAPS : value >> 1;
endmodule

// File: rtl/platform_field.sv
// platform_field: scrolls and recycles eight platforms, tracks score; PLAT_MOVING_EN makes odd platforms slide sideways.
module platform_field #(
  parameter int H           = 480,
  parameter int X_min       = 140,
  parameter int X_max       = 499,
  parameter int SCROLL_LINE = 160,
  parameter int MAX_SCROLL  = 24,
  parameter int PLAT_SIZE   = platform_pkg::PLAT_SIZE
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  frame_clk_edge,
  input  logic [7:0]  state,
  input  logic [9:0]  Doodle_Y,
  output logic [9:0]  Platform_X [0:7],
  output logic [9:0]  Platform_Y [0:7],
  output logic [7:0]  platform_size,
  output logic [15:0] score,
  output logic        busy
);
  import platform_pkg::*;
  localparam int X_HI = X_max - PLAT_SIZE;
  fsm_t fsm, fsm_nx;
  logic [2:0] idx;
  logic [9:0] scroll, sc_nx, diff, rand_x, x_cur, x_nx;
  logic [10:0] ny;
  logic [16:0] sum;
  logic [15:0] lfsr;
  logic [8:0] r;
  logic wrap, frame, unused_lfsr;
`ifdef PLAT_MOVING_EN
  logic [N_PLAT-1:0] dir;
  logic dir_nx;
`endif
  lfsr16 u_lfsr (.Clk(Clk), .Reset(Reset), .value(lfsr));
  assign platform_size = 8'(PLAT_SIZE);
  assign busy = fsm != IDLE;
  assign frame = frame_clk_edge == 2'b01;
  assign r = lfsr[8:0];
  assign unused_lfsr = ^lfsr[15:9];
  // Out-of-range draws fold back by 256 so every X fits the playfield.
  assign rand_x = 10'(X_min) + {1'b0, r} - (r > 9'(X_HI - X_min) ? 10'd256 : 10'd0);
  always_comb begin
    fsm_nx = fsm == IDLE ? (frame && state == PLAY ? SCAN : frame && state == MENU ? INIT : IDLE)
           : fsm == SCAN ? (idx == 3'(N_PLAT - 1) ? IDLE : SCAN) : IDLE;
    diff = 10'(SCROLL_LINE) - Doodle_Y;
    sc_nx = Doodle_Y < 10'(SCROLL_LINE) ? (diff > 10'(MAX_SCROLL) ? 10'(MAX_SCROLL) : diff) : '0;
    sum = {1'b0, score} + 17'(sc_nx);
    ny = {1'b0, Platform_Y[idx]} + {1'b0, scroll};
    wrap = ny >= 11'(H);
    x_cur = Platform_X[idx];
    x_nx = wrap ? rand_x : x_cur;
`ifdef PLAT_MOVING_EN
    dir_nx = dir[idx];
    if (idx[0] && !wrap) begin
      x_nx = dir[idx] ? (x_cur - 10'd1 <= 10'(X_min) ? 10'(X_min) : x_cur - 10'd1)
                      : (x_cur + 10'd1 >= 10'(X_HI) ? 10'(X_HI) : x_cur + 10'd1);
      dir_nx = dir[idx] ? x_cur - 10'd1 > 10'(X_min) : x_cur + 10'd1 >= 10'(X_HI);
    end
`endif
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fsm <= IDLE;
      idx <= '0;
      scroll <= '0;
      score <= '0;
      Platform_X <= INIT_X;
      Platform_Y <= INIT_Y;
`ifdef PLAT_MOVING_EN
      dir <= '0;
`endif
    end else begin
      fsm <= fsm_nx;
      if (fsm == IDLE && fsm_nx == SCAN) begin
        scroll <= sc_nx;
        idx <= '0;
        score <= sum[16] ? 16'hFFFF : sum[15:0];
      end
      if (fsm == INIT) begin
        Platform_X <= INIT_X;
        Platform_Y <= INIT_Y;
        score <= '0;
`ifdef PLAT_MOVING_EN
        dir <= '0;
`endif
      end
      if (fsm == SCAN) begin
        Platform_Y[idx] <= 10'(wrap ? ny - 11'(H) : ny);
        Platform_X[idx] <= x_nx;
`ifdef PLAT_MOVING_EN
        dir[idx] <= dir_nx;
`endif
        idx <= idx + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_platform_field.sv
// tb_platform_field: directed self-checking bench for platform_field.
module tb_platform_field;
  logic Clk = 0, Reset = 0;
  logic [1:0] frame_clk_edge = 0;
  logic [7:0] state = 8'd1;
  logic [9:0] Doodle_Y = 10'd300;
  logic [9:0] px [0:7];
  logic [9:0] py [0:7];
  logic [7:0] platform_size;
  logic [15:0] score;
  logic busy;
  int checks = 0, errors = 0, n;
  platform_field dut (.Clk(Clk), .Reset(Reset), .frame_clk_edge(frame_clk_edge), .state(state),
    .Doodle_Y(Doodle_Y), .Platform_X(px), .Platform_Y(py), .platform_size(platform_size),
    .score(score), .busy(busy));
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic run_frame(output int cnt);
    @(negedge Clk) frame_clk_edge = 2'b01;
    @(negedge Clk) frame_clk_edge = 2'b00;
    cnt = 0;
    while (busy && cnt < 20) begin
      cnt++;
      @(negedge Clk);
    end
  endtask
  initial begin
    repeat (3) @(negedge Clk);
    chk("rst_y0", py[0], 440);
    chk("rst_y7", py[7], 20);
    chk("rst_x3", px[3], 431);
    chk("rst_score", score, 0);
    chk("rst_busy", busy, 0);
    chk("size", platform_size, 60);
    Reset = 1;
    repeat (2) @(negedge Clk);
    run_frame(n);
    chk("noscroll_busy", n, 8);
    chk("noscroll_y0", py[0], 440);
    chk("noscroll_y7", py[7], 20);
    chk("noscroll_score", score, 0);
    Doodle_Y = 10'd150;
    run_frame(n);
    chk("s10_y0", py[0], 450);
    chk("s10_y3", py[3], 270);
    chk("s10_y7", py[7], 30);
    chk("s10_score", score, 10);
    chk("s10_x2", px[2], 334);
    state = 8'd0;
    run_frame(n);
    chk("init_busy", n, 1);
    chk("init_y0", py[0], 440);
    chk("init_score", score, 0);
    state = 8'd1;
    Doodle_Y = 10'd100;
    run_frame(n);
    chk("cap_y0_a", py[0], 464);
    run_frame(n);
    chk("cap_y0_b", py[0], 8);
    chk("cap_x0_range", int'(px[0] >= 140 && px[0] <= 439), 1);
    run_frame(n);
    chk("cap_y0_c", py[0], 32);
    chk("cap_y7", py[7], 92);
    chk("cap_score", score, 72);
    chk("cap_x4", px[4], 228);
    Doodle_Y = 10'd159;
    run_frame(n);
    chk("edge159_score", score, 73);
    chk("edge159_y7", py[7], 93);
    Doodle_Y = 10'd160;
    run_frame(n);
    chk("edge160_score", score, 73);
    state = 8'd2;
    run_frame(n);
    chk("pause_busy", n, 0);
    chk("pause_score", score, 73);
    state = 8'd1;
    Doodle_Y = 10'd100;
    @(negedge Clk) frame_clk_edge = 2'b01;
    @(negedge Clk) frame_clk_edge = 2'b00;
    repeat (3) @(negedge Clk);
    Reset = 0;
    #1;
    chk("abort_y0", py[0], 440);
    chk("abort_y7", py[7], 20);
    chk("abort_x0", px[0], 140);
    chk("abort_score", score, 0);
    chk("abort_busy", busy, 0);
    @(negedge Clk) Reset = 1;
`ifdef PLAT_MOVING_EN
    Doodle_Y = 10'd300;
    repeat (202) run_frame(n);
    chk("move_x1_max", px[1], 439);
    run_frame(n);
    chk("move_x1_back", px[1], 438);
    chk("move_x0", px[0], 140);
    chk("move_x2", px[2], 334);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/platform_field.md
# platform_field

Generates and scrolls the eight platforms the doodle block collides against. Owns the camera: when the doodle rises above a scroll line, all platforms shift down by the excess. Platforms leaving the bottom are recycled to the top with a pseudo-random X. Drives the doodle block's Platform_X, Platform_Y and platform_size inputs directly, and produces the running score for the HUD.

## Interface
Parameters:
- H, 480, screen height in pixels
- X_min, 140, leftmost playfield column
- X_max, 499, rightmost playfield column
- SCROLL_LINE, 160, doodle Y above which scrolling occurs
- MAX_SCROLL, 24, per-frame scroll cap in pixels
- PLAT_SIZE, 60, platform width in pixels

Ports:
- Clk  input  1  50 MHz system clock
- Reset  input  1  asynchronous, active-low reset
- frame_clk_edge  input  2  frame-edge detect; 2'b01 marks frame start
- state  input  8  game state: 0 = menu, 1 = play, others = pause
- Doodle_Y  input  10  doodle top Y, from the doodle block
- Platform_X  output  10 x [0:7]  platform left X
- Platform_Y  output  10 x [0:7]  platform top Y
- platform_size  output  8  constant PLAT_SIZE
- score  output  16  accumulated scroll distance, saturating
- busy  output  1  high while the per-frame update runs

## Operation
- FSM with three states: IDLE, SCAN, INIT.
  - IDLE to SCAN: on frame_clk_edge==2'b01 with state==1. The block latches scroll = (Doodle_Y < SCROLL_LINE) ? min(SCROLL_LINE − Doodle_Y, MAX_SCROLL) : 0. It sets idx=0.
  - IDLE to INIT: on frame_clk_edge==2'b01 with state==0.
  - In other states, frame edges are ignored.
- SCAN processes one platform per cycle, platform idx:
  - ny = Platform_Y[idx] + scroll, computed 11-bit.
  - If ny ≥ H: Platform_Y[idx] = ny − H, and Platform_X[idx] = rand_x.
  - Else: Platform_Y[idx] = ny.
  - After idx==7, return to IDLE.
- rand_x: r = lfsr[8:0]. Result is X_min + r if r ≤ X_max − X_min − PLAT_SIZE (299); otherwise X_min + r − 256. The result is always within [X_min, X_max − PLAT_SIZE].
- LFSR:
  - 16-bit Galois, taps 16'hB400, seed 16'hACE1.
  - Advances every Clk cycle, including during reset release. It is never zero.
- INIT loads the fixed layout in one cycle, then returns to IDLE. score clears to 0.
  - Platform_Y[i] = 440 − 60·i.
  - Platform_X[i] = X_min + ((97·i) mod 300), i.e. 140, 237, 334, 431, 228, 325, 422, 219.
- score += scroll once per SCAN entry, saturating at 16'hFFFF.
- Spacing is preserved modulo H: recycling shifts by exactly H.

## Timing
- Reset (async assert, sync release): FSM=IDLE, outputs = INIT layout, score=0, busy=0, lfsr=seed.
- busy is high during SCAN (exactly 8 cycles) and INIT (1 cycle).
- Platform i's update is visible at cycle i+1 after the edge. All updates complete by the 9th cycle, long before the next frame edge.
- Doodle samples platforms only at frame edges, so it sees a consistent set from the previous frame.
- A frame edge arriving while busy is ignored; this cannot happen at 60 Hz.
- A Reset assertion mid-SCAN aborts immediately to the reset values.
- platform_size is constant PLAT_SIZE and unaffected by reset.

## Configuration
- PLAT_MOVING_EN defined:
  - Odd-index platforms move horizontally 1 px per frame, applied in SCAN.
  - Each has a direction bit (reset/INIT = right). The bit flips when X would pass X_max − PLAT_SIZE or X_min, and that step clamps to the limit.
  - A recycled platform keeps its direction bit.
- Undefined: all platforms are horizontally static, and no direction registers exist.

## Structure
- Package platform_pkg holds:
  - N_PLAT=8, PLAT_SIZE, LFSR seed and taps.
  - The game-state encoding (MENU=0, PLAY=1).
  - The FSM state enum.
  - The INIT X/Y constant arrays.
- Sub-module lfsr16: Clk, Reset, 16-bit output; seed and taps come from the package.

## Test plan
- Reset released, state=1, Doodle_Y=300, one frame edge: Platform_Y unchanged (440…20), score=0, busy high for 8 cycles.
- Doodle_Y=150, one edge: every Platform_Y +10 (450…30), score=10.
- Doodle_Y=100, three edges: scroll capped at 24 per frame. Platform0 (440) goes 464, then recycles to 8 with X in [140,439]; score=72.
- state=0, one edge after scrolling: layout restored to the INIT values, score=0, busy high for 1 cycle.
- Reset asserted at SCAN cycle 4: outputs return to INIT values immediately, with no partial update remaining.
- PLAT_MOVING_EN defined, Platform1 X=237, Doodle_Y=300, 203 edges: X reaches 439, then decreases to 438. Even platforms' X are unchanged.
